// File: rtl/if_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: stall vector, instruction/address types,
// fetch FSM states and reset constants used by the fetch controller slice.
package if_fetch_ctrl_pkg;

    typedef logic [5:0]  Stall_t;
    typedef logic [31:0] Inst_t;
    typedef logic [31:0] Inst_addr_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_FULL,
        FS_DISCARD
    } fetch_state_t;

    localparam Inst_t      ZERO_WORD     = 32'h0000_0000;
    localparam Inst_addr_t PC_RESET_ADDR = 32'hBFC0_0000;

    // Index of the IF/ID hold bit inside Stall_t.
    localparam int STALL_IF_ID = 1;

    function automatic Inst_addr_t next_pc(input Inst_addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and the
// instruction memory / TLB side (slave).
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic       ibus_req;
    Inst_addr_t ibus_addr;
    logic       ibus_ack;
    Inst_t      ibus_rdata;
    logic       ibus_miss;
    logic       ibus_valid;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_ack,
        input  ibus_rdata,
        input  ibus_miss,
        input  ibus_valid
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_ack,
        output ibus_rdata,
        output ibus_miss,
        output ibus_valid
    );

endinterface

// File: rtl/if_fetch_buf.sv
// One-entry fetch packet register. Clear beats load beats consume.
// Optional IFETCH_ALIGN_CHECK_EN adds an address-error flag to the packet.
module if_fetch_buf
    import if_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       consume,
    input  Inst_addr_t load_pc,
    input  Inst_t      load_inst,
    input  logic       load_miss,
    input  logic       load_valid,
`ifdef IFETCH_ALIGN_CHECK_EN
    input  logic       load_err,
    output logic       pkt_err,
`endif
    output logic       pkt_vld,
    output Inst_addr_t pkt_pc,
    output Inst_t      pkt_inst,
    output logic       pkt_miss,
    output logic       pkt_valid
);

    logic       pkt_vld_reg;
    Inst_addr_t pkt_pc_reg;
    Inst_t      pkt_inst_reg;
    logic       pkt_miss_reg;
    logic       pkt_valid_reg;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic       pkt_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_vld_reg   <= 1'b0;
            pkt_pc_reg    <= '0;
            pkt_inst_reg  <= ZERO_WORD;
            pkt_miss_reg  <= 1'b0;
            pkt_valid_reg <= 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
            pkt_err_reg   <= 1'b0;
`endif
        end else if (clear) begin
            pkt_vld_reg <= 1'b0;
        end else if (load) begin
            // A load replaces a packet consumed in the same cycle.
            pkt_vld_reg   <= 1'b1;
            pkt_pc_reg    <= load_pc;
            pkt_inst_reg  <= load_inst;
            pkt_miss_reg  <= load_miss;
            pkt_valid_reg <= load_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
            pkt_err_reg   <= load_err;
`endif
        end else if (consume) begin
            pkt_vld_reg <= 1'b0;
        end
    end

    assign pkt_vld   = pkt_vld_reg;
    assign pkt_pc    = pkt_pc_reg;
    assign pkt_inst  = pkt_inst_reg;
    assign pkt_miss  = pkt_miss_reg;
    assign pkt_valid = pkt_valid_reg;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign pkt_err   = pkt_err_reg;
`endif

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues ibus requests, handles redirects and
// feeds IF/ID through if_fetch_buf. IFETCH_ALIGN_CHECK_EN adds if_addr_err.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter Inst_addr_t RESET_PC = PC_RESET_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  Stall_t     stall,
    input  logic       flush,
    input  Inst_addr_t flush_pc,
    input  logic       branch_flag,
    input  Inst_addr_t branch_target,
    if_fetch_ctrl_if.master ibus,
    output Inst_addr_t if_pc,
    output Inst_t      if_inst,
    output logic       if_miss,
    output logic       if_valid,
    output Inst_addr_t if_inst_addr_v,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic       if_addr_err,
`endif
    output logic       stall_req
);

    fetch_state_t state_reg;
    Inst_addr_t   fetch_pc_reg;
    Inst_addr_t   discard_addr_reg;

    logic       pkt_vld;
    Inst_addr_t pkt_pc;
    Inst_t      pkt_inst;
    logic       pkt_miss;
    logic       pkt_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic       pkt_err;
`endif

    logic       consume;
    logic       slot_free;
    logic       redirect;
    Inst_addr_t redirect_pc;
    logic       misaligned;
    logic       req_c;
    logic       ack;
    logic       err_load;
    logic       buf_load;
    logic       stall_unused;

    assign stall_unused = ^{stall[5:2], stall[0]};

    assign consume     = pkt_vld & ~stall[STALL_IF_ID];
    assign slot_free   = ~pkt_vld | consume;
    assign redirect    = flush | branch_flag;
    assign redirect_pc = flush ? flush_pc : branch_target;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (fetch_pc_reg[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The request is gated by this cycle's stall so a held packet never has a
    // successor in flight; once raised it stays up because the slot stays free.
    assign req_c    = ((state_reg == FS_REQ) && slot_free && !misaligned)
                    || (state_reg == FS_DISCARD);
    assign ack      = ibus.ibus_ack & req_c;
    assign err_load = (state_reg == FS_REQ) && slot_free && misaligned;
    assign buf_load = (state_reg == FS_REQ) && (ack || err_load) && !redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= FS_IDLE;
            fetch_pc_reg     <= RESET_PC;
            discard_addr_reg <= RESET_PC;
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    state_reg <= FS_REQ;
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                    end
                end
                FS_REQ: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                        if (req_c && !ack) begin
                            state_reg        <= FS_DISCARD;
                            discard_addr_reg <= fetch_pc_reg;
                        end else begin
                            state_reg <= FS_REQ;
                        end
                    end else if (!slot_free) begin
                        state_reg <= FS_FULL;
                    end else if (ack || err_load) begin
                        fetch_pc_reg <= next_pc(fetch_pc_reg);
                    end
                end
                FS_FULL: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                        state_reg    <= FS_REQ;
                    end else if (consume) begin
                        state_reg <= FS_REQ;
                    end
                end
                FS_DISCARD: begin
                    // The bus keeps the stale address until it answers; a newer
                    // redirect just replaces the target to restart from.
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                    end
                    if (ack) begin
                        state_reg <= FS_REQ;
                    end
                end
                default: begin
                    state_reg <= FS_IDLE;
                end
            endcase
        end
    end

    if_fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect),
        .load       (buf_load),
        .consume    (consume),
        .load_pc    (fetch_pc_reg),
        .load_inst  (err_load ? ZERO_WORD : ibus.ibus_rdata),
        .load_miss  (err_load ? 1'b0 : ibus.ibus_miss),
        .load_valid (err_load ? 1'b1 : ibus.ibus_valid),
`ifdef IFETCH_ALIGN_CHECK_EN
        .load_err   (err_load),
        .pkt_err    (pkt_err),
`endif
        .pkt_vld    (pkt_vld),
        .pkt_pc     (pkt_pc),
        .pkt_inst   (pkt_inst),
        .pkt_miss   (pkt_miss),
        .pkt_valid  (pkt_valid)
    );

    assign ibus.ibus_req  = req_c;
    assign ibus.ibus_addr = (state_reg == FS_DISCARD) ? discard_addr_reg : fetch_pc_reg;

    // With no packet held, IF/ID sees a NOP tagged with the pending fetch PC.
    assign if_pc          = pkt_vld ? pkt_pc    : fetch_pc_reg;
    assign if_inst_addr_v = if_pc;
    assign if_inst        = pkt_vld ? pkt_inst  : ZERO_WORD;
    assign if_miss        = pkt_vld ? pkt_miss  : 1'b0;
    assign if_valid       = pkt_vld ? pkt_valid : 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign if_addr_err    = pkt_vld ? pkt_err   : 1'b0;
`endif

    assign stall_req = ~pkt_vld | (state_reg == FS_DISCARD);

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (0 = reset).
REQ-004 stall  in  6 (Stall_t)  pipeline stall vector; bit1 = IF/ID hold.
REQ-005 flush  in  1  exception/ERET redirect; flush_pc  in  32  its target.
REQ-006 branch_flag  in  1  branch redirect; branch_target  in  32  its target.
REQ-007 ibus_req  out  1; ibus_addr  out  32  (virtual fetch address).
REQ-008 ibus_ack  in  1  bus response; ibus_rdata  in  32; ibus_miss  in  1  TLB refill; ibus_valid  in  1  TLB entry valid.
REQ-009 if_pc  out  32; if_inst  out  32; if_miss  out  1; if_valid  out  1; if_inst_addr_v  out  32 -- fetch packet presented to IF/ID.
REQ-010 stall_req  out  1  fetch-side stall request to the pipeline controller.

Function
REQ-011 States SHALL be IDLE, REQ, FULL, DISCARD; a 1-entry packet register (pkt_vld, pc, inst, miss, valid) SHALL drive all if_* outputs.
REQ-012 IDLE: ibus_req=0; next state REQ unconditionally.
REQ-013 REQ: ibus_req=1, ibus_addr=fetch_pc, both held stable until ibus_ack.
REQ-014 ibus_ack in REQ without redirect SHALL load packet (pc=fetch_pc, inst=ibus_rdata, miss=ibus_miss, valid=ibus_valid, pkt_vld=1) and set fetch_pc=fetch_pc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-015 Packet consumed when pkt_vld=1 and stall[1]=0; consumption and new load in the same cycle SHALL yield back-to-back packets (1 inst/cycle at zero-wait bus).
REQ-016 ibus_req SHALL assert only when pkt_vld=0 or packet consumed this cycle; otherwise state FULL, ibus_req=0, until consumption, then REQ.
REQ-017 Redirect = flush OR branch_flag; flush SHALL take priority; target = flush ? flush_pc : branch_target.
REQ-018 On redirect: pkt_vld<=0, fetch_pc<=target in the same edge; from REQ without ack -> DISCARD; from REQ with ack, IDLE or FULL -> REQ; returning data SHALL NOT be loaded.
REQ-019 DISCARD: ibus_req=1 on the old address until ibus_ack, data dropped, then REQ at target; a further redirect in DISCARD SHALL overwrite the target and remain DISCARD.
REQ-020 stall_req SHALL equal ~pkt_vld OR state==DISCARD (combinational).
REQ-021 When pkt_vld=0, if_inst SHALL be 32'h0 (NOP), if_miss=0, if_valid=1, if_pc/if_inst_addr_v=fetch_pc.
REQ-022 if_pc and if_inst_addr_v SHALL both carry the packet virtual PC.

Reset
REQ-023 rst=0 SHALL force state IDLE, fetch_pc=RESET_PC, pkt_vld=0, ibus_req=0, if_inst=0, if_miss=0, if_valid=1, if_pc=if_inst_addr_v=RESET_PC.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request; an ibus_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-025 With IFETCH_ALIGN_CHECK_EN defined: output if_addr_err (1) added; fetch_pc[1:0]!=0 SHALL load a packet immediately with inst=0, if_addr_err=1, no ibus_req issued.
REQ-026 Without IFETCH_ALIGN_CHECK_EN: port absent, address low bits passed to the bus unchecked.

Structure
REQ-027 Stall_t, Inst_t, Inst_addr_t, fetch state enum, ZERO_WORD and PC_RESET_ADDR SHALL live in the shared cpu defines package.
REQ-028 The packet register SHALL be a sub-module if_fetch_buf (load/consume/clear, 1 entry); FSM stays in if_fetch_ctrl.

Verification
REQ-029 Reset release, ack every cycle -> ibus_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; if_inst follows rdata one cycle later.
REQ-030 stall=6'b000011 for 3 cycles with pkt_vld=1 -> ibus_req=0, if_pc held 0xBFC00004, resumes 0xBFC00008 after release.
REQ-031 branch_flag=1, target 0x80001000 during REQ, ack 2 cycles later -> that data dropped, next ibus_addr 0x80001000, stall_req=1 throughout.
REQ-032 flush (pc 0x80000180) and branch_flag same cycle -> next fetch 0x80000180.
REQ-033 ibus_miss=1, ibus_valid=0 on ack -> if_miss=1, if_valid=0 on that packet only.
REQ-034 IFETCH_ALIGN_CHECK_EN, branch to 0x80000002 -> if_addr_err=1, no ibus_req for that address.
